dkong_audio_mixer: RTL and testbench
====================================

Name: dkong_audio_mixer

Overview:
- Parametrised N-channel audio mixer that replaces the fixed WAV + digital + walk summing at the end of the sound board.
- Runs one sample tick per CLK_DIV clocks (48 kHz from 24.576 MHz by default).
- Mixes every channel through a time-multiplexed multiply-accumulate, one channel per clock, then saturates to OUT_W.
- Presents signed and offset-binary outputs to the audio path, plus a one-cycle sample strobe.

Parameters:
NUM_CH, 4, number of input channels (1..16)
IN_W, 16, per-channel sample width, signed two's complement
GAIN_W, 8, per-channel gain width, unsigned; unity = 2**(GAIN_W-1)
OUT_W, 16, output width, signed
CLK_DIV, 512, clocks per sample tick; must be >= NUM_CH+3
DC_SHIFT, 10, DC-block pole shift K (optional feature only)

Ports:
W_CLK_24576M  in   1                single clock
W_RESET       in   1                asynchronous reset, active-high
I_CH_DAT      in   NUM_CH*IN_W      packed signed samples, channel 0 in LSBs
I_CH_GAIN     in   NUM_CH*GAIN_W    packed unsigned gains
I_CH_EN       in   NUM_CH           per-channel enable mask
I_MUTE        in   1                force output to zero
O_SOUND_DAT   out  OUT_W            signed mixed sample
O_SOUND_DAT_U out  OUT_W            O_SOUND_DAT with MSB inverted (offset binary)
O_SAMPLE_VLD  out  1                one-cycle pulse when the outputs update
O_CLIP        out  1                high with O_SAMPLE_VLD when the sample saturated
O_BUSY        out  1                high during SNAP/ACC/OUT

Behaviour:
- Reset values (async, immediate):
  - Divider = 0; FSM = IDLE; accumulator = 0; snapshot = 0.
  - O_SOUND_DAT = 0; O_SOUND_DAT_U = 2**(OUT_W-1); O_SAMPLE_VLD = 0; O_CLIP = 0; O_BUSY = 0.
- Divider: counts 0..CLK_DIV-1 and wraps to 0. Tick = divider==CLK_DIV-1. First tick occurs CLK_DIV clocks after reset release.
- FSM:
  - IDLE: on tick -> SNAP.
  - SNAP: registers all I_CH_DAT, I_CH_GAIN and I_CH_EN into a snapshot; clears accumulator and channel index; -> ACC. Inputs may change freely after this edge.
  - ACC: for index i = 0..NUM_CH-1, one per clock: acc += en[i] ? (sample[i] * {1'b0, gain[i]}) : 0. After i = NUM_CH-1 -> OUT.
  - OUT: r = acc >>> (GAIN_W-1), arithmetic shift, floor rounding. Saturate r to [-2**(OUT_W-1), 2**(OUT_W-1)-1]. If I_MUTE (sampled in OUT) then r = 0 and no clip. Register outputs, pulse O_SAMPLE_VLD, set O_CLIP = saturated. -> IDLE.
- Latency: tick at edge t; SNAP at t+1; ACC at t+2..t+NUM_CH+1; outputs and strobe valid at t+NUM_CH+2 for exactly one cycle.
- Outputs hold between strobes. O_CLIP falls with O_SAMPLE_VLD.
- Widths:
  - Product = IN_W+GAIN_W+1 bits, signed.
  - Accumulator = IN_W+GAIN_W+1+clog2(NUM_CH) bits, which cannot overflow.
- A tick cannot arrive while busy, given the CLK_DIV constraint. Simulation asserts CLK_DIV >= NUM_CH+3.
- Reset mid-operation: the FSM aborts with no strobe, outputs return to reset values, and the divider restarts.
- NUM_CH = 1: ACC lasts one cycle. Index width = max(1, clog2(NUM_CH)).

Optional Feature:
- Macro: DKONG_MIX_DCBLOCK_EN.
- When defined: a one-pole DC blocker sits between saturation and the output register, stage OUT followed by stage FLT (one extra cycle, so the strobe moves to t+NUM_CH+3).
  - Filter: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
  - State registers are OUT_W+4 bits and reset to 0.
  - The result is saturated to OUT_W. O_CLIP is the OR of both saturation points.
  - I_MUTE zeroes the output but the filter state still updates with x = 0.
- When undefined: no filter logic, the latency is as stated above, and the DC_SHIFT parameter is ignored.

Test Plan:
(NUM_CH=4, IN_W=16, GAIN_W=8, OUT_W=16, CLK_DIV=512, macro undefined unless noted)
- Reset: assert W_RESET with random inputs -> O_SOUND_DAT = 0, O_SOUND_DAT_U = 0x8000, O_SAMPLE_VLD = 0; first strobe 512+6 clocks after release.
- Unity single channel: ch0 = 1000, gain0 = 128, other gains 0, en = 4'hF -> O_SOUND_DAT = 1000, O_SOUND_DAT_U = 0x83E8, O_CLIP = 0, strobe 6 clocks after tick, one cycle wide.
- Saturation: ch0 = ch1 = 20000, gains 128 -> 32767 with O_CLIP = 1; ch0 = ch1 = -20000 -> -32768 with O_CLIP = 1.
- Gain rounding and mask: ch0 = -1001, gain0 = 64 -> -501; same stimulus with en[0] = 0 -> 0. Inputs changed one cycle after SNAP have no effect on the current sample.
- Mute and reset mid-ACC: I_MUTE = 1 with ch0 = 5000 -> output 0, O_CLIP = 0. W_RESET pulsed during ACC -> no strobe, outputs at reset values, next strobe 518 clocks after release.
- DKONG_MIX_DCBLOCK_EN defined: constant ch0 = 10000 at unity -> first output 10000, then monotonically decays below 100 within 5000 samples; strobe at tick+7.

Source files
------------

// File: rtl/dkong_audio_mixer.sv
// dkong_audio_mixer: N-channel sample mixer for the end of the sound board.
// One sample tick per CLK_DIV clocks; inputs are snapshotted, run through a
// time-multiplexed multiply-accumulate (one channel per clock), scaled by the
// gain unity point, saturated to OUT_W and presented with a one-cycle strobe.
// Optional build macro DKONG_MIX_DCBLOCK_EN inserts a one-pole DC blocker
// (pole shift DC_SHIFT) after saturation, adding one cycle of latency.
module dkong_audio_mixer #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned IN_W     = 16,
   parameter int unsigned GAIN_W   = 8,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned CLK_DIV  = 512,
   parameter int unsigned DC_SHIFT = 10
) (
   input  logic                     W_CLK_24576M,
   input  logic                     W_RESET,
   input  logic [NUM_CH*IN_W-1:0]   I_CH_DAT,
   input  logic [NUM_CH*GAIN_W-1:0] I_CH_GAIN,
   input  logic [NUM_CH-1:0]        I_CH_EN,
   input  logic                     I_MUTE,
   output logic [OUT_W-1:0]         O_SOUND_DAT,
   output logic [OUT_W-1:0]         O_SOUND_DAT_U,
   output logic                     O_SAMPLE_VLD,
   output logic                     O_CLIP,
   output logic                     O_BUSY
);

   localparam int unsigned PW = IN_W + GAIN_W + 1;
   localparam int unsigned AW = PW + $clog2(NUM_CH);
   localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SH = GAIN_W - 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

   // Output range expressed at accumulator width (AW >= OUT_W for any sane set)
   localparam logic signed [AW-1:0] ACC_MAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   generate
      if (CLK_DIV < NUM_CH + 3) begin : g_bad_div
         $error("dkong_audio_mixer: CLK_DIV must be >= NUM_CH+3");
      end
      if (DC_SHIFT >= 32) begin : g_bad_shift
         $error("dkong_audio_mixer: DC_SHIFT out of range");
      end
   endgenerate

`ifdef DKONG_MIX_DCBLOCK_EN
   typedef enum logic [2:0] {S_IDLE, S_SNAP, S_ACC, S_OUT, S_FLT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SNAP, S_ACC, S_OUT} state_t;
`endif

   state_t                   state;
   logic [DW-1:0]            div_cnt;
   logic                     tick;
   logic [IW-1:0]            idx;
   logic signed [AW-1:0]     acc;

   logic signed [IN_W-1:0]   snap_dat  [NUM_CH];
   logic [GAIN_W-1:0]        snap_gain [NUM_CH];
   logic [NUM_CH-1:0]        snap_en;

   logic signed [PW-1:0]     cur_prod;
   logic signed [AW-1:0]     term;
   logic signed [AW-1:0]     acc_sh;
   logic [OUT_W-1:0]         sat_r;
   logic                     sat_hit;

   assign tick          = (div_cnt == DIV_LAST);
   assign O_SOUND_DAT_U = {~O_SOUND_DAT[OUT_W-1], O_SOUND_DAT[OUT_W-2:0]};

   // Current channel's weighted term, and the scaled/saturated accumulator
   always_comb begin
      cur_prod = PW'(snap_dat[idx]) * PW'($signed({1'b0, snap_gain[idx]}));
      term     = snap_en[idx] ? AW'(cur_prod) : '0;
      acc_sh   = acc >>> SH;
      sat_hit  = 1'b0;
      sat_r    = acc_sh[OUT_W-1:0];
      if (acc_sh > ACC_MAX) begin
         sat_r   = {1'b0, {(OUT_W-1){1'b1}}};
         sat_hit = 1'b1;
      end else if (acc_sh < ACC_MIN) begin
         sat_r   = {1'b1, {(OUT_W-1){1'b0}}};
         sat_hit = 1'b1;
      end
   end

`ifdef DKONG_MIX_DCBLOCK_EN
   localparam int unsigned FW = OUT_W + 4;
   localparam logic signed [FW-1:0] FLT_MAX = {5'b00000, {(OUT_W-1){1'b1}}};
   localparam logic signed [FW-1:0] FLT_MIN = {5'b11111, {(OUT_W-1){1'b0}}};

   logic signed [FW-1:0] x_cur, x_prev, y_prev, flt_y;
   logic [OUT_W-1:0]     flt_sat;
   logic                 flt_hit, clip_q, mute_q;

   // One-pole DC blocker on the saturated sample, then re-saturation
   always_comb begin
      flt_y   = x_cur - x_prev + y_prev - (y_prev >>> DC_SHIFT);
      flt_hit = 1'b0;
      flt_sat = flt_y[OUT_W-1:0];
      if (flt_y > FLT_MAX) begin
         flt_sat = {1'b0, {(OUT_W-1){1'b1}}};
         flt_hit = 1'b1;
      end else if (flt_y < FLT_MIN) begin
         flt_sat = {1'b1, {(OUT_W-1){1'b0}}};
         flt_hit = 1'b1;
      end
   end
`endif

   // Sample divider, snapshot/MAC sequencer and registered outputs
   always_ff @(posedge W_CLK_24576M or posedge W_RESET) begin
      if (W_RESET) begin
         state        <= S_IDLE;
         div_cnt      <= '0;
         idx          <= '0;
         acc          <= '0;
         snap_en      <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            snap_dat[i]  <= '0;
            snap_gain[i] <= '0;
         end
         O_SOUND_DAT  <= '0;
         O_SAMPLE_VLD <= 1'b0;
         O_CLIP       <= 1'b0;
         O_BUSY       <= 1'b0;
`ifdef DKONG_MIX_DCBLOCK_EN
         x_cur        <= '0;
         x_prev       <= '0;
         y_prev       <= '0;
         clip_q       <= 1'b0;
         mute_q       <= 1'b0;
`endif
      end else begin
         div_cnt      <= tick ? '0 : div_cnt + 1'b1;
         O_SAMPLE_VLD <= 1'b0;
         O_CLIP       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tick) begin
                  state  <= S_SNAP;
                  O_BUSY <= 1'b1;
               end
            end
            S_SNAP: begin
               for (int unsigned i = 0; i < NUM_CH; i++) begin
                  snap_dat[i]  <= I_CH_DAT[i*IN_W +: IN_W];
                  snap_gain[i] <= I_CH_GAIN[i*GAIN_W +: GAIN_W];
               end
               snap_en <= I_CH_EN;
               acc     <= '0;
               idx     <= '0;
               state   <= S_ACC;
            end
            S_ACC: begin
               acc <= acc + term;
               if (idx == IDX_LAST) state <= S_OUT;
               else                 idx   <= idx + 1'b1;
            end
`ifdef DKONG_MIX_DCBLOCK_EN
            S_OUT: begin
               // Muted samples still feed the filter, as a zero input
               x_cur  <= I_MUTE ? '0 : {{4{sat_r[OUT_W-1]}}, sat_r};
               clip_q <= !I_MUTE && sat_hit;
               mute_q <= I_MUTE;
               state  <= S_FLT;
            end
            S_FLT: begin
               x_prev       <= x_cur;
               y_prev       <= flt_y;
               O_SOUND_DAT  <= mute_q ? '0 : flt_sat;
               O_CLIP       <= !mute_q && (clip_q || flt_hit);
               O_SAMPLE_VLD <= 1'b1;
               O_BUSY       <= 1'b0;
               state        <= S_IDLE;
            end
`else
            S_OUT: begin
               O_SOUND_DAT  <= I_MUTE ? '0 : sat_r;
               O_CLIP       <= !I_MUTE && sat_hit;
               O_SAMPLE_VLD <= 1'b1;
               O_BUSY       <= 1'b0;
               state        <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dkong_audio_mixer.sv
// Bench for dkong_audio_mixer: directed and random samples against a
// behavioural mixing model (integer sum of products, floor scale, clamp).
module tb_dkong_audio_mixer;

   localparam int NCH  = 4;
   localparam int INW  = 16;
   localparam int GW   = 8;
   localparam int OW   = 16;
   localparam int CDIV = 512;
`ifdef DKONG_MIX_DCBLOCK_EN
   localparam int LAT  = NCH + 3;
`else
   localparam int LAT  = NCH + 2;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH*INW-1:0]  ch_dat;
   logic [NCH*GW-1:0]   ch_gain;
   logic [NCH-1:0]      ch_en;
   logic                mute;
   logic [OW-1:0]       snd_dat, snd_dat_u;
   logic                vld, clip, busy;

   int total = 0;
   int bad   = 0;

   int            sd [NCH];
   int            gd [NCH];
   logic [NCH-1:0] ed;
   logic          md;
   longint        xp, yp;
   int            since;

   dkong_audio_mixer #(
      .NUM_CH(NCH), .IN_W(INW), .GAIN_W(GW), .OUT_W(OW), .CLK_DIV(CDIV), .DC_SHIFT(10)
   ) dut (
      .W_CLK_24576M (clk),
      .W_RESET      (rst),
      .I_CH_DAT     (ch_dat),
      .I_CH_GAIN    (ch_gain),
      .I_CH_EN      (ch_en),
      .I_MUTE       (mute),
      .O_SOUND_DAT  (snd_dat),
      .O_SOUND_DAT_U(snd_dat_u),
      .O_SAMPLE_VLD (vld),
      .O_CLIP       (clip),
      .O_BUSY       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NCH; i++) begin
         ch_dat[i*INW +: INW] = sd[i][INW-1:0];
         ch_gain[i*GW +: GW]  = gd[i][GW-1:0];
      end
      ch_en = ed;
      mute  = md;
   endtask

   task automatic rand_vals(input bit big);
      for (int i = 0; i < NCH; i++) begin
         if (big) sd[i] = int'($urandom_range(0, 65535)) - 32768;
         else     sd[i] = int'($urandom_range(0, 8000)) - 4000;
         gd[i] = int'($urandom_range(0, 255));
      end
      ed = NCH'($urandom);
      md = ($urandom_range(0, 7) == 0);
   endtask

   function automatic longint clamp(input longint v, output bit hit);
      hit = 1'b0;
      if (v > 32767)  begin hit = 1'b1; return 32767;  end
      if (v < -32768) begin hit = 1'b1; return -32768; end
      return v;
   endfunction

`ifdef DKONG_MIX_DCBLOCK_EN
   function automatic longint wrap20(input longint v);
      longint w;
      w = v & 64'hFFFFF;
      if (w >= 524288) w = w - 1048576;
      return w;
   endfunction
`endif

   // Expected output of the next sample from the values last driven
   task automatic model(output longint o, output longint c);
      longint sum, r;
      bit     h1;
      sum = 0;
      for (int i = 0; i < NCH; i++)
         if (ed[i]) sum += longint'(sd[i]) * longint'(gd[i]);
      r = clamp(sum >>> (GW - 1), h1);
      if (md) begin r = 0; h1 = 1'b0; end
`ifdef DKONG_MIX_DCBLOCK_EN
      begin
         longint y;
         bit     h2;
         y  = wrap20(r - xp + yp - (yp >>> 10));
         xp = r;
         yp = y;
         o  = clamp(y, h2);
         c  = (!md && (h1 || h2)) ? 1 : 0;
         if (md) o = 0;
      end
`else
      o = r;
      c = h1 ? 1 : 0;
`endif
   endtask

   // Wait for the next sample; check latency from the tick, data, clip and strobe width
   task automatic run_sample(input string tag, input bit perturb, output int cyc);
      int     n, m;
      longint eo, ec;
      n = 0;
      m = 0;
      while (!busy && n < CDIV + 10) begin
         @(posedge clk); #1; n++;
      end
      if (!busy) begin
         chk({tag, "_busy_timeout"}, 0, 1);
         cyc = n;
         return;
      end
      while (!vld && m < 20) begin
         @(posedge clk); #1; m++;
         if (perturb && m == 1) begin
            ch_dat  = {$urandom, $urandom};
            ch_gain = $urandom;
            ch_en   = NCH'($urandom);
         end
      end
      cyc = n + m;
      if (!vld) begin
         chk({tag, "_strobe_timeout"}, 0, 1);
         return;
      end
      chk({tag, "_lat"}, m, LAT);
      model(eo, ec);
      chk({tag, "_dat"}, longint'($signed(snd_dat)), eo);
      chk({tag, "_dat_u"}, longint'(snd_dat_u), eo + 32768);
      chk({tag, "_clip"}, longint'(clip), ec);
      @(posedge clk); #1;
      chk({tag, "_vld_width"}, longint'(vld), 0);
      chk({tag, "_clip_fall"}, longint'(clip), 0);
   endtask

   task automatic set_vals(input int d0, input int d1, input int g0, input int g1,
                           input logic [NCH-1:0] en, input logic mu);
      for (int i = 0; i < NCH; i++) begin
         sd[i] = int'($urandom_range(0, 2000)) - 1000;
         gd[i] = 0;
      end
      sd[0] = d0; sd[1] = d1; gd[0] = g0; gd[1] = g1;
      ed = en;
      md = mu;
      drive();
   endtask

   initial begin
      xp = 0;
      yp = 0;
      rst = 1'b1;
      rand_vals(1'b1);
      md = 1'b0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dat", longint'(snd_dat), 0);
      chk("rst_dat_u", longint'(snd_dat_u), 32768);
      chk("rst_vld", longint'(vld), 0);
      chk("rst_clip", longint'(clip), 0);
      chk("rst_busy", longint'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      run_sample("first", 1'b0, since);
      chk("first_strobe_cycles", since, CDIV + LAT);

      set_vals(1000, 0, 128, 0, 4'hF, 1'b0);
      run_sample("unity", 1'b0, since);
`ifndef DKONG_MIX_DCBLOCK_EN
      chk("unity_const", longint'($signed(snd_dat)), 1000);
      chk("unity_const_u", longint'(snd_dat_u), 16'h83E8);

      set_vals(20000, 20000, 128, 128, 4'hF, 1'b0);
      run_sample("sat_pos", 1'b0, since);
      chk("sat_pos_const", longint'($signed(snd_dat)), 32767);

      set_vals(-20000, -20000, 128, 128, 4'hF, 1'b0);
      run_sample("sat_neg", 1'b0, since);
      chk("sat_neg_const", longint'($signed(snd_dat)), -32768);

      set_vals(-1001, 0, 64, 0, 4'hF, 1'b0);
      run_sample("round", 1'b0, since);
      chk("round_const", longint'($signed(snd_dat)), -501);

      set_vals(-1001, 0, 64, 0, 4'hE, 1'b0);
      run_sample("mask", 1'b0, since);
      chk("mask_const", longint'($signed(snd_dat)), 0);

      set_vals(5000, 0, 128, 0, 4'hF, 1'b1);
      run_sample("mute", 1'b0, since);
      chk("mute_const", longint'($signed(snd_dat)), 0);
`endif

      rand_vals(1'b0);
      md = 1'b0;
      drive();
      run_sample("late_change", 1'b1, since);

      // Reset pulse during the accumulate phase
      rand_vals(1'b1);
      drive();
      begin
         int n;
         n = 0;
         while (!busy && n < CDIV + 10) begin
            @(posedge clk); #1; n++;
         end
         chk("midrst_busy_seen", longint'(busy), 1);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_dat", longint'(snd_dat), 0);
      chk("midrst_dat_u", longint'(snd_dat_u), 32768);
      chk("midrst_vld", longint'(vld), 0);
      chk("midrst_busy", longint'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      xp = 0;
      yp = 0;
      rand_vals(1'b1);
      drive();
      run_sample("after_rst", 1'b0, since);
      chk("after_rst_cycles", since, CDIV + LAT);

      for (int k = 0; k < 16; k++) begin
         rand_vals(k[0]);
         drive();
         run_sample("rand", 1'b0, since);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
